rr_mux_select_arbiter: RTL and testbench



---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_pick4.sv | 26 ++
 rtl/rr_mux_select_arbiter.sv | 92 +++++++++
 tb/tb_rr_mux_select_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the 4:1 mux select arbiter
package mux_pkg;

    localparam int NUM_SRC = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotating priority encoder: first set req bit at or after ptr
module rr_pick4
    import mux_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] w_cand;

    // Walk offsets from farthest to nearest so the closest set bit to ptr wins.
    always_comb begin
        idx    = 2'd0;
        w_cand = 2'd0;
        any    = |req;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_cand = ptr + 2'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// rtl/rr_mux_select_arbiter.sv - round-robin arbiter driving the select of a 4:1 mux
module rr_mux_select_arbiter
    import mux_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] S,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int CNT_W = ($clog2(HOLD_MAX + 1) < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           r_state;
    sel_t             r_sel;
    sel_t             r_ptr;
    logic [3:0]       r_gnt;
    logic             r_gnt_valid;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;

    sel_t             w_idx;
    logic             w_any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_idx),
        .any (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= 2'b00;
            r_ptr       <= 2'b00;
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_state     <= GRANT;
                        r_sel       <= w_idx;
                        r_gnt       <= 4'b0001 << w_idx;
                        r_gnt_valid <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                GRANT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Normal release outranks the timeout when both hit on the same edge.
                    if (done || !req[r_sel]) begin
                        r_state     <= GAP;
                        r_ptr       <= r_sel + 2'd1;
                        r_gnt       <= 4'b0000;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b0;
                    end else if ((HOLD_MAX != 0) && (r_cnt == HOLD_LAST)) begin
                        r_state     <= GAP;
                        r_ptr       <= r_sel + 2'd1;
                        r_gnt       <= 4'b0000;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                    end
                end
                GAP: begin
                    r_timeout <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign S         = r_sel;
    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// tb/tb_rr_mux_select_arbiter.sv - directed self-checking bench for rr_mux_select_arbiter
module tb_rr_mux_select_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] S;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int n_total;
    int n_pass;

    rr_mux_select_arbiter #(
        .HOLD_MAX (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .S         (S),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [1:0] s_exp, input logic [3:0] g_exp,
                               input logic v_exp, input logic t_exp);
        check({tag, ".S"}, 32'(S), 32'(s_exp));
        check({tag, ".gnt"}, 32'(gnt), 32'(g_exp));
        check({tag, ".valid"}, 32'(gnt_valid), 32'(v_exp));
        check({tag, ".timeout"}, 32'(timeout), 32'(t_exp));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        req     = 4'b0000;
        done    = 1'b0;
        rst     = 1'b1;
        #1;
        check_state("reset", 2'b00, 4'b0000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Single request, done-terminated
        req = 4'b0100;
        tick();
        check_state("t1_grant", 2'b10, 4'b0100, 1'b1, 1'b0);
        tick();
        tick();
        done = 1'b1;
        tick();
        check_state("t1_gap", 2'b10, 4'b0000, 1'b0, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        check_state("t1_idle", 2'b10, 4'b0000, 1'b0, 1'b0);
        tick();
        check("t1_stay_idle", 32'(gnt_valid), 32'd0);

        // All requesting: rotation 0,1,2,3,0 with two dead cycles between grants
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_state($sformatf("t2_grant%0d", k), 2'(k % 4), 4'b0001 << (k % 4), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            check($sformatf("t2_gap%0d", k), 32'(gnt_valid), 32'd0);
            tick();
            check($sformatf("t2_idle%0d", k), 32'(gnt_valid), 32'd0);
            tick();
        end

        // Hold timeout with a lone requester, then re-grant to the same source
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_state($sformatf("t3_hold%0d", k), 2'b01, 4'b0010, 1'b1, 1'b0);
        end
        tick();
        check_state("t3_gap_to", 2'b01, 4'b0000, 1'b0, 1'b1);
        tick();
        check_state("t3_idle", 2'b01, 4'b0000, 1'b0, 1'b0);
        tick();
        check_state("t3_regrant", 2'b01, 4'b0010, 1'b1, 1'b0);

        // done on the last permitted cycle wins over the timeout
        tick();
        tick();
        tick();
        check("t4_still_valid", 32'(gnt_valid), 32'd1);
        done = 1'b1;
        tick();
        check_state("t4_gap", 2'b01, 4'b0000, 1'b0, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        check("t4_idle_to", 32'(timeout), 32'd0);

        // Source 3 drops its request; other req bits churn without effect
        do_reset();
        req = 4'b1000;
        tick();
        check_state("t5_grant3", 2'b11, 4'b1000, 1'b1, 1'b0);
        req = 4'b1111;
        tick();
        req = 4'b1001;
        tick();
        check_state("t5_churn", 2'b11, 4'b1000, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check_state("t5_drop", 2'b11, 4'b0000, 1'b0, 1'b0);
        tick();
        req = 4'b1001;
        tick();
        check_state("t5_wrap", 2'b00, 4'b0001, 1'b1, 1'b0);

        // Release source 0; ptr moves to 1 so source 3 wins next, then reset mid-grant
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        check_state("t6_grant3", 2'b11, 4'b1000, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_state("t6_async_rst", 2'b00, 4'b0000, 1'b0, 1'b0);
        tick();
        req = 4'b0000;
        rst = 1'b0;
        tick();
        check("t6_idle_after", 32'(gnt_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
